// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port indices for the memory arbiter.
package mem_arb_pkg;
  localparam int ARB_PORTS = 2;
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: clearable, saturating cycle counter for the WAIT timeout.
module mem_arb_timer #(
  parameter int TIMEOUT = 1024,
  parameter int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter for a single memory port with WAIT timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ARB_PORTS-1:0]   req_ce,
  input  logic [ARB_PORTS-1:0]   req_we,
  input  logic [3*ARB_PORTS-1:0] req_funct3,
  input  logic [32*ARB_PORTS-1:0] req_addr,
  input  logic [32*ARB_PORTS-1:0] req_wdata,
  output logic [ARB_PORTS-1:0]   req_busy,
  output logic [ARB_PORTS-1:0]   rsp_valid,
  output logic [ARB_PORTS-1:0]   rsp_err,
  output logic [31:0]            rsp_rdata,
  output logic [ARB_PORTS-1:0]   grant,
  output logic                   m_ce,
  output logic                   m_we,
  output logic [2:0]             m_funct3,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_datain,
  input  logic [31:0]            m_dataout,
  input  logic                   m_busy,
  input  logic                   m_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic last;
  logic sel;
  logic timeout;
  logic [CW-1:0] cnt;
  // On a tie the port that did not win last time goes next.
  assign sel = (req_ce == 2'b11) ? ~last : ~req_ce[PORT_CPU];
  assign timeout = cnt >= CW'(TIMEOUT - 1);
  assign m_ce = state == ISSUE && !m_busy;
  assign req_busy = req_ce & ~rsp_valid;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (m_ce),
    .en   (state == WAIT),
    .cnt  (cnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= 1'(PORT_DMA);
      m_we      <= 1'b0;
      m_funct3  <= '0;
      m_addr    <= '0;
      m_datain  <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      case (state)
        IDLE: if (|req_ce) begin
          state    <= ISSUE;
          grant    <= {sel, ~sel};
          last     <= sel;
          m_we     <= sel ? req_we[1] : req_we[0];
          m_funct3 <= sel ? req_funct3[5:3] : req_funct3[2:0];
          m_addr   <= sel ? req_addr[63:32] : req_addr[31:0];
          m_datain <= sel ? req_wdata[63:32] : req_wdata[31:0];
        end
        ISSUE: if (!m_busy) state <= WAIT;
        WAIT: if (m_valid || timeout) begin
          state     <= RESP;
          m_we      <= 1'b0;
          rsp_valid <= grant;
          rsp_err   <= m_valid ? '0 : grant;
          if (m_valid) rsp_rdata <= m_dataout;
        end
        RESP: begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-timeline reference model with directed and randomized traffic.
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 0, reset = 1;
  logic [1:0] req_ce = 0, req_we = 0;
  logic [5:0] req_funct3 = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_busy, rsp_valid, rsp_err, grant;
  logic [31:0] rsp_rdata, m_addr, m_datain;
  logic [31:0] m_dataout = 0;
  logic m_ce, m_we, m_busy = 0, m_valid = 0;
  logic [2:0] m_funct3;

  int n_cmp = 0, n_bad = 0;
  logic model_last;
  logic [31:0] model_rdata;
  logic [1:0] op_we;
  logic [2:0] op_f3 [2];
  logic [31:0] op_addr [2];
  logic [31:0] op_wd [2];
  logic [31:0] rd_data;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_ce(req_ce), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_busy(req_busy), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .grant(grant), .m_ce(m_ce), .m_we(m_we),
    .m_funct3(m_funct3), .m_addr(m_addr), .m_datain(m_datain), .m_dataout(m_dataout),
    .m_busy(m_busy), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One transaction as a cycle timeline: cycle 0 is the IDLE cycle presenting the request,
  // m_ce lands after the busy cycles, the response one cycle after m_valid or the timeout.
  task automatic run_txn(input logic [1:0] ce, input int busy_n, input int lat, input bit drop,
                         input bit late, input string tag, output int port);
    int p, m, r;
    bit to;
    logic [1:0] oh, ce_now, exp_rv, exp_g, exp_err;
    logic exp_we;
    p = (ce == 2'b11) ? (model_last ? 0 : 1) : (ce[1] ? 1 : 0);
    model_last = p[0];
    oh = 2'b01 << p;
    to = lat > TO;
    m = busy_n + 1;
    r = m + (to ? TO : lat) + 1;
    req_we = op_we;
    req_funct3 = {op_f3[1], op_f3[0]};
    req_addr = {op_addr[1], op_addr[0]};
    req_wdata = {op_wd[1], op_wd[0]};
    for (int c = 0; c <= r; c++) begin
      ce_now = (drop && c > m) ? ce & ~oh : ce;
      req_ce = ce_now;
      m_busy = c >= 1 && c <= busy_n;
      m_valid = (!to && c == m + lat) || (to && late && c == r) || (c <= m && $urandom_range(0, 3) == 0);
      m_dataout = (!to && c == m + lat) ? rd_data : $urandom;
      exp_rv = (c == r) ? oh : 2'b00;
      exp_err = (c == r && to) ? oh : 2'b00;
      exp_g = (c == 0) ? 2'b00 : oh;
      exp_we = c >= 1 && c < r && op_we[p];
      if (c == r && !to) model_rdata = rd_data;
      #1;
      n_cmp += 7;
      if (grant !== exp_g) begin n_bad++; $display("FAIL %s grant c=%0d got %b exp %b", tag, c, grant, exp_g); end
      if (m_ce !== (c == m)) begin n_bad++; $display("FAIL %s m_ce c=%0d got %b exp %b", tag, c, m_ce, c == m); end
      if (m_we !== exp_we) begin n_bad++; $display("FAIL %s m_we c=%0d got %b exp %b", tag, c, m_we, exp_we); end
      if (rsp_valid !== exp_rv) begin n_bad++; $display("FAIL %s rsp_valid c=%0d got %b exp %b", tag, c, rsp_valid, exp_rv); end
      if (rsp_err !== exp_err) begin n_bad++; $display("FAIL %s rsp_err c=%0d got %b exp %b", tag, c, rsp_err, exp_err); end
      if (rsp_rdata !== model_rdata) begin n_bad++; $display("FAIL %s rsp_rdata c=%0d got %h exp %h", tag, c, rsp_rdata, model_rdata); end
      if (req_busy !== (ce_now & ~exp_rv)) begin n_bad++; $display("FAIL %s req_busy c=%0d got %b exp %b", tag, c, req_busy, ce_now & ~exp_rv); end
      if (c >= 1 && c < r) begin
        n_cmp += 3;
        if (m_addr !== op_addr[p]) begin n_bad++; $display("FAIL %s m_addr c=%0d got %h exp %h", tag, c, m_addr, op_addr[p]); end
        if (m_datain !== op_wd[p]) begin n_bad++; $display("FAIL %s m_datain c=%0d got %h exp %h", tag, c, m_datain, op_wd[p]); end
        if (m_funct3 !== op_f3[p]) begin n_bad++; $display("FAIL %s m_funct3 c=%0d got %h exp %h", tag, c, m_funct3, op_f3[p]); end
      end
      @(posedge clk); #1;
    end
    req_ce = 0;
    m_valid = 0;
    m_busy = 0;
    port = p;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      op_we[i] = 1'($urandom);
      op_f3[i] = 3'($urandom);
      op_addr[i] = $urandom;
      op_wd[i] = $urandom;
    end
    rd_data = $urandom;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 6;
    if (grant !== 2'b00) begin n_bad++; $display("FAIL reset grant got %b exp 00", grant); end
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin n_bad++; $display("FAIL reset rsp got %b/%b exp 00/00", rsp_valid, rsp_err); end
    if (m_ce !== 1'b0 || m_we !== 1'b0) begin n_bad++; $display("FAIL reset m_ce/m_we got %b/%b exp 0/0", m_ce, m_we); end
    if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset rsp_rdata got %h exp 0", rsp_rdata); end
    if (m_addr !== 32'h0 || m_datain !== 32'h0 || m_funct3 !== 3'h0) begin n_bad++; $display("FAIL reset operands got %h/%h/%h exp 0", m_addr, m_datain, m_funct3); end
    if (req_busy !== 2'b00) begin n_bad++; $display("FAIL reset req_busy got %b exp 00", req_busy); end
    reset = 0;
    model_last = 1'b1;
    model_rdata = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    int p;
    rand_ops();
    run_txn(2'b11, 0, 2, 0, 0, "tie_first", p);
    rand_ops();
    run_txn(2'b10, 0, 1, 0, 0, "tie_pending", p);
    rand_ops();
    run_txn(2'b11, 1, 3, 0, 0, "tie_again", p);
    rand_ops();
    run_txn(2'b11, 0, 2, 0, 0, "tie_alt", p);
  endtask

  task automatic test_cpu_read();
    int p;
    rand_ops();
    op_we = 2'b00;
    op_f3[0] = 3'b010;
    op_addr[0] = 32'h100;
    op_wd[0] = 32'h0;
    rd_data = 32'hDEADBEEF;
    run_txn(2'b01, 0, 3, 0, 0, "cpu_read", p);
  endtask

  task automatic test_dma_busy();
    int p;
    rand_ops();
    op_we = 2'b10;
    op_f3[1] = 3'b010;
    op_addr[1] = 32'h2000;
    op_wd[1] = 32'h12345678;
    run_txn(2'b10, 5, 4, 0, 0, "dma_busy", p);
  endtask

  task automatic test_timeout();
    int p;
    rand_ops();
    run_txn(2'b01, 0, 99, 0, 1, "timeout_late", p);
    rand_ops();
    run_txn(2'b10, 2, TO, 0, 0, "valid_at_limit", p);
    rand_ops();
    run_txn(2'b11, 0, TO + 1, 0, 0, "timeout_edge", p);
    rand_ops();
    run_txn(2'b01, 1, 1, 1, 0, "early_drop", p);
  endtask

  task automatic test_reset_mid();
    int p;
    rand_ops();
    op_we = 2'b01;
    req_we = op_we;
    req_addr = {op_addr[1], op_addr[0]};
    req_wdata = {op_wd[1], op_wd[0]};
    req_ce = 2'b01;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (grant !== 2'b01 || m_we !== 1'b1) begin n_bad++; $display("FAIL rst_mid pre grant/m_we got %b/%b exp 01/1", grant, m_we); end
    reset = 1;
    req_ce = 0;
    #1;
    n_cmp += 5;
    if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_mid grant got %b exp 00", grant); end
    if (m_ce !== 1'b0 || m_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid m_ce/m_we got %b/%b exp 0/0", m_ce, m_we); end
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin n_bad++; $display("FAIL rst_mid rsp got %b/%b exp 00/00", rsp_valid, rsp_err); end
    if (m_addr !== 32'h0 || m_datain !== 32'h0) begin n_bad++; $display("FAIL rst_mid operands got %h/%h exp 0/0", m_addr, m_datain); end
    if (rsp_rdata !== 32'h0 || req_busy !== 2'b00) begin n_bad++; $display("FAIL rst_mid rdata/busy got %h/%b exp 0/00", rsp_rdata, req_busy); end
    m_valid = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_mid hold rsp_valid got %b exp 00", rsp_valid); end
    m_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    model_last = 1'b1;
    model_rdata = 0;
    @(posedge clk); #1;
    rand_ops();
    run_txn(2'b11, 0, 2, 0, 0, "after_reset", p);
  endtask

  task automatic test_random();
    logic [1:0] pend, ce;
    int p;
    pend = 0;
    for (int t = 0; t < 40; t++) begin
      if (pend == 0 && $urandom_range(0, 3) == 0) begin
        req_ce = 0;
        #1;
        n_cmp++;
        if (grant !== 2'b00) begin n_bad++; $display("FAIL rand_idle grant got %b exp 00", grant); end
        @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++)
        if (!pend[i]) begin
          op_we[i] = 1'($urandom);
          op_f3[i] = 3'($urandom);
          op_addr[i] = $urandom;
          op_wd[i] = $urandom;
        end
      rd_data = $urandom;
      ce = pend | 2'($urandom);
      if (ce == 2'b00) ce = 2'($urandom_range(1, 3));
      run_txn(ce, $urandom_range(0, 3), $urandom_range(1, 10), $urandom_range(0, 3) == 0,
              1'($urandom), "rand", p);
      pend = ce & ~(2'b01 << p);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_cpu_read();
    test_dma_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: the maximum number of WAIT cycles before a transaction is aborted with an error.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_ce  input  2  per-port request; bit 0 = CPU port, bit 1 = DMA port.
REQ-005 req_we  input  2  per-port write enable.
REQ-006 req_funct3  input  6  per-port access size; port i uses bits [3i+2:3i].
REQ-007 req_addr  input  64  per-port byte address; port i uses bits [32i+31:32i].
REQ-008 req_wdata  input  64  per-port write data, packed the same way as req_addr.
REQ-009 req_busy  output  2  per-port busy: request pending and not yet answered.
REQ-010 rsp_valid  output  2  one-cycle completion pulse for the granted port.
REQ-011 rsp_err  output  2  timeout flag, qualified by rsp_valid.
REQ-012 rsp_rdata  output  32  read data, shared by both ports, qualified by rsp_valid.
REQ-013 grant  output  2  one-hot owner of the memory port; 0 in IDLE.
REQ-014 m_ce, m_we  output  1 each  memory start strobe and write enable.
REQ-015 m_funct3 / m_addr / m_datain  output  3/32/32  memory access size, address and write data.
REQ-016 m_dataout, m_busy, m_valid  input  32/1/1  memory read data, busy and completion.

Function
REQ-017 The arbiter SHALL implement exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE arbitration:
- one port requesting: that port is granted.
- both ports requesting: the port not granted last is granted (round robin).
- the grant is registered and the request's we/funct3/addr/wdata are latched; next state is ISSUE.
REQ-019 ISSUE: m_ce SHALL pulse for exactly one cycle, in the first ISSUE cycle with m_busy=0; while m_busy=1 the arbiter stays in ISSUE with m_ce=0; next state is WAIT.
REQ-020 WAIT: the cycle counter SHALL increment each cycle; m_valid=1 captures m_dataout into rsp_rdata and moves to RESP with err=0.
REQ-021 Timeout: if the counter reaches TIMEOUT-1 without m_valid, the arbiter SHALL move to RESP with err=1 and leave rsp_rdata unchanged.
REQ-022 RESP: rsp_valid[g] and rsp_err[g] SHALL be asserted for one cycle for the granted port g only; next state is IDLE, where grant clears.
REQ-023 Latency: req_ce sampled in IDLE at cycle N with m_busy=0 SHALL give m_ce at N+1; m_valid at N+1+k (k≥1) SHALL give rsp_valid at N+2+k; back-to-back grants are at most once per 4 cycles.
REQ-024 m_we/m_addr/m_funct3/m_datain SHALL come from the latched registers, stable from ISSUE through WAIT; m_we SHALL be 0 outside ISSUE/WAIT.
REQ-025 req_busy[i] SHALL equal req_ce[i] & ~rsp_valid[i].
REQ-026 Requesters hold req_ce and operands until rsp_valid; if the granted port drops req_ce early, the transaction SHALL still complete and pulse rsp_valid.
REQ-027 m_valid outside WAIT SHALL be ignored.
REQ-028 After a timeout, the next ISSUE SHALL gate on m_busy=0, so a straggling access cannot be attributed to a new grant.
REQ-029 The counter SHALL be $clog2(TIMEOUT+1) bits wide, cleared on entry to WAIT, and saturate rather than wrap.
REQ-030 Simultaneous arrival: a request arriving in RESP for the other port SHALL be granted in the following IDLE cycle.

Reset
REQ-031 On reset: state=IDLE; grant, m_ce, m_we, rsp_valid, rsp_err, req_busy-internal state, counter, rsp_rdata, and latched operands all 0; last-grant=DMA, so the CPU wins the first tie.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no rsp_valid pulse.

Structure
REQ-033 Package mem_arb_pkg SHALL hold:
- the state enum.
- PORT_CPU=0 and PORT_DMA=1.
- the ARB_PORTS=2 constant.
REQ-034 The FUNCT3 memory constants SHALL be reused from the existing shared constants file.
REQ-035 A single sub-module mem_arb_timer SHALL contain the clearable, saturating TIMEOUT counter; arbitration and the FSM stay in mem_arbiter.

Verification
REQ-036 CPU read alone, addr 0x100, m_valid 3 cycles after m_ce with data 0xDEADBEEF -> rsp_valid[0] one cycle later, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Both ports request simultaneously after reset -> CPU granted first; DMA granted at the first IDLE after the CPU's RESP; a repeated tie alternates.
REQ-038 DMA write addr 0x2000 data 0x12345678 with m_busy high for 5 cycles -> m_ce delayed until m_busy=0; m_we=1 and m_addr/m_datain stable through WAIT.
REQ-039 TIMEOUT=8, m_valid never arrives -> rsp_valid+rsp_err on the granted port 8 WAIT cycles after m_ce; a late m_valid is ignored.
REQ-040 Reset asserted during WAIT -> all outputs 0 asynchronously, no rsp_valid; a new request after release completes normally.
